// File: rtl/sync_level_multi.sv
// Multi-channel level resynchroniser with optional per-channel glitch filter and edge strobes.
// Latency: STAGES cycles to dataOut (filter bypassed), STAGES+FILTER_LEN cycles with filter.
// Backpressure: none; free-running, every channel is sampled on every syncClk edge.
//
// Ports:
//   syncClk   - resynchronisation clock (single domain)
//   syncRst   - synchronous active-high reset
//   dataIn    - WIDTH asynchronous quasi-static levels
//   dataOut   - WIDTH resynchronised (optionally filtered) levels
//   riseOut   - WIDTH one-cycle strobes, set in the cycle dataOut[i] becomes 1
//   fallOut   - WIDTH one-cycle strobes, set in the cycle dataOut[i] becomes 0
//   anyChange - OR of all rise/fall strobes
module sync_level_multi #(
  parameter int               WIDTH      = 1,
  parameter int               STAGES     = 2,
  parameter int               FILTER_LEN = 0,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
  input  logic             syncClk,
  input  logic             syncRst,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic [WIDTH-1:0] riseOut,
  output logic [WIDTH-1:0] fallOut,
  output logic             anyChange
);

  // Plain flop chain, no logic between stages; r_sync[0] may go metastable.
  logic [WIDTH-1:0] r_sync [STAGES];
  logic [WIDTH-1:0] w_syncd;
  // Value dataOut will hold after the next edge; the strobes are derived from it
  // so that they are registered yet coincide with the dataOut change.
  logic [WIDTH-1:0] w_out_nxt;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  always_ff @(posedge syncClk) begin
    if (syncRst) begin
      for (int s = 0; s < STAGES; s++) begin
        r_sync[s] <= RESET_VAL;
      end
    end else begin
      r_sync[0] <= dataIn;
      for (int s = 1; s < STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_syncd = r_sync[STAGES-1];

  generate
    if (FILTER_LEN == 0) begin : g_nofilt
      assign dataOut   = w_syncd;
      // Without a filter, dataOut's next value is the stage feeding the last flop.
      assign w_out_nxt = r_sync[STAGES-2];
    end else begin : g_filt
      localparam int              CNT_W    = $clog2(FILTER_LEN + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

      logic [CNT_W-1:0] r_cnt     [WIDTH];
      logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
      logic [WIDTH-1:0] r_out;

      // cnt counts consecutive cycles the synchronised level has disagreed with
      // dataOut; agreement clears it, so short excursions are forgotten.
      always_comb begin
        w_out_nxt = r_out;
        for (int i = 0; i < WIDTH; i++) begin
          w_cnt_nxt[i] = '0;
          if (w_syncd[i] != r_out[i]) begin
            if (r_cnt[i] == CNT_LAST) begin
              w_out_nxt[i] = w_syncd[i];
            end else begin
              w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
          end
        end
      end

      always_ff @(posedge syncClk) begin
        if (syncRst) begin
          r_out <= RESET_VAL;
          for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
          end
        end else begin
          r_out <= w_out_nxt;
          for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
          end
        end
      end

      assign dataOut = r_out;
    end
  endgenerate

  // Strobes are forced low through reset, so the reset load never reads as an edge.
  always_ff @(posedge syncClk) begin
    if (syncRst) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_out_nxt & ~dataOut;
      r_fall <= ~w_out_nxt & dataOut;
    end
  end

  assign riseOut   = r_rise;
  assign fallOut   = r_fall;
  assign anyChange = |(r_rise | r_fall);

endmodule

// File: tb/tb_sync_level_multi.sv
// Bench for sync_level_multi: five differently parameterised instances on one clock,
// directed scenarios followed by randomized levels, all checked every cycle against
// a window-based reference model of the resynchroniser and filter.
module tb_sync_level_multi;

  localparam int NI   = 5;
  localparam int MAXN = 4096;
  localparam int               WA  [NI] = '{4, 1, 4, 1, 32};
  localparam int               SA  [NI] = '{2, 3, 2, 2, 3};
  localparam int               FA  [NI] = '{0, 4, 2, 8, 3};
  localparam logic [31:0]      RVA [NI] = '{32'h0, 32'h0, 32'hA, 32'h0, 32'hA5A5_0F0F};

  logic                  clk;
  logic [NI-1:0]         rst;
  logic [NI-1:0][31:0]   din;
  logic [NI-1:0][31:0]   got_do;
  logic [NI-1:0][31:0]   got_ri;
  logic [NI-1:0][31:0]   got_fa;
  logic [NI-1:0]         got_any;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int W = WA[k];
    wire [W-1:0] d_o;
    wire [W-1:0] r_o;
    wire [W-1:0] f_o;
    wire         a_o;

    sync_level_multi #(
      .WIDTH     (W),
      .STAGES    (SA[k]),
      .FILTER_LEN(FA[k]),
      .RESET_VAL (RVA[k][W-1:0])
    ) u_dut (
      .syncClk  (clk),
      .syncRst  (rst[k]),
      .dataIn   (din[k][W-1:0]),
      .dataOut  (d_o),
      .riseOut  (r_o),
      .fallOut  (f_o),
      .anyChange(a_o)
    );

    assign got_do[k]  = 32'(d_o);
    assign got_ri[k]  = 32'(r_o);
    assign got_fa[k]  = 32'(f_o);
    assign got_any[k] = a_o;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;          // index of the most recent clock edge

  // Reference model state
  logic [31:0] hist [NI][MAXN];   // dataIn sampled at each edge
  logic [31:0] eout [NI][MAXN];   // expected dataOut after each edge
  logic [31:0] erise [NI];
  logic [31:0] efall [NI];
  int          rlast [NI];        // most recent edge with reset asserted
  int          hold  [NI][32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(input int k);
    return (WA[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << WA[k]) - 32'd1);
  endfunction

  // Synchronised level after edge m: dataIn taken STAGES-1 edges earlier, unless
  // a reset lies within that span, in which case the chain still holds RESET_VAL.
  function automatic logic [31:0] syncd_of(input int k, input int m);
    int idx;
    idx = m - SA[k] + 1;
    if (idx > rlast[k]) return hist[k][idx];
    return RVA[k] & mask_of(k);
  endfunction

  // dataOut flips a bit only when the synchronised level has shown the opposite
  // value on each of the FILTER_LEN previous cycles, none of them before a reset.
  task automatic model_step(input int k);
    logic [31:0] prev;
    logic [31:0] nxt;
    logic [31:0] s;
    logic        steady;
    if (rst[k]) begin
      rlast[k]   = n;
      eout[k][n] = RVA[k] & mask_of(k);
      erise[k]   = '0;
      efall[k]   = '0;
    end else begin
      prev = eout[k][n-1];
      if (FA[k] == 0) begin
        nxt = syncd_of(k, n);
      end else begin
        nxt = prev;
        if (n - FA[k] >= rlast[k]) begin
          for (int b = 0; b < WA[k]; b++) begin
            steady = 1'b1;
            for (int j = 1; j <= FA[k]; j++) begin
              s = syncd_of(k, n - j);
              if (s[b] == prev[b]) steady = 1'b0;
            end
            if (steady) nxt[b] = ~prev[b];
          end
        end
      end
      eout[k][n] = nxt & mask_of(k);
      erise[k]   = nxt & ~prev & mask_of(k);
      efall[k]   = ~nxt & prev & mask_of(k);
    end
  endtask

  // One clock edge: record inputs, advance the model, compare every instance 1ns later.
  task automatic tick();
    @(posedge clk);
    n++;
    if (n >= MAXN) begin
      $display("FAIL edge_budget edge=%0d got=%0d exp<%0d", n, n, MAXN);
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "edge budget exhausted");
    end
    for (int k = 0; k < NI; k++) begin
      hist[k][n] = din[k] & mask_of(k);
      model_step(k);
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("i%0d.dataOut", k), got_do[k], eout[k][n]);
      chk($sformatf("i%0d.riseOut", k), got_ri[k], erise[k]);
      chk($sformatf("i%0d.fallOut", k), got_fa[k], efall[k]);
      chk($sformatf("i%0d.anyChange", k), 32'(got_any[k]), 32'(|(erise[k] | efall[k])));
      chk($sformatf("i%0d.rise_and_fall", k), got_ri[k] & got_fa[k], 32'h0);
    end
  endtask

  initial begin
    rst = '1;
    din = '0;
    din[2] = 32'hA;
    for (int k = 0; k < NI; k++) begin
      rlast[k] = 0;
      for (int b = 0; b < 32; b++) hold[k][b] = 0;
    end

    // Reset held 3 cycles, then released with inst2 input equal to its RESET_VAL.
    repeat (3) tick();
    chk("reset.i0.dataOut", got_do[0], 32'h0);
    chk("reset.i2.dataOut", got_do[2], 32'hA);
    chk("reset.i4.dataOut", got_do[4], 32'hA5A5_0F0F);
    chk("reset.i2.anyChange", 32'(got_any[2]), 32'h0);
    rst = '0;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("rstval.i2.dataOut", got_do[2], 32'hA);
      chk("rstval.i2.anyChange", 32'(got_any[2]), 32'h0);
    end

    // Unfiltered 2-stage: 0000 -> 0101 visible after edge E+1 with one strobe.
    din[0] = 32'h5;
    tick();
    chk("nofilt.E.dataOut", got_do[0], 32'h0);
    tick();
    chk("nofilt.E1.dataOut", got_do[0], 32'h5);
    chk("nofilt.E1.riseOut", got_ri[0], 32'h5);
    chk("nofilt.E1.anyChange", 32'(got_any[0]), 32'h1);
    tick();
    chk("nofilt.E2.riseOut", got_ri[0], 32'h0);
    chk("nofilt.E2.anyChange", 32'(got_any[0]), 32'h0);

    // STAGES=3, FILTER_LEN=4: rise and fall each appear after edge E+6.
    din[1] = 32'h1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j == 5) chk("filt.rise.E5.dataOut", got_do[1], 32'h0);
      if (j == 6) begin
        chk("filt.rise.E6.dataOut", got_do[1], 32'h1);
        chk("filt.rise.E6.riseOut", got_ri[1], 32'h1);
      end
    end
    din[1] = 32'h0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j == 5) chk("filt.fall.E5.dataOut", got_do[1], 32'h1);
      if (j == 6) begin
        chk("filt.fall.E6.dataOut", got_do[1], 32'h0);
        chk("filt.fall.E6.fallOut", got_fa[1], 32'h1);
      end
    end

    // 3-cycle glitch is rejected; a following 6-cycle pulse passes.
    din[1] = 32'h1;
    repeat (3) tick();
    din[1] = 32'h0;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("glitch.dataOut", got_do[1], 32'h0);
      chk("glitch.anyChange", 32'(got_any[1]), 32'h0);
    end
    din[1] = 32'h1;
    for (int j = 0; j < 14; j++) begin
      tick();
      if (j == 5) din[1] = 32'h0;
      if (j == 6) begin
        chk("pulse6.dataOut", got_do[1], 32'h1);
        chk("pulse6.riseOut", got_ri[1], 32'h1);
      end
    end

    // FILTER_LEN=8: reset pulse with cnt=5 restarts the full qualification.
    din[3] = 32'h1;
    for (int j = 0; j <= 6; j++) tick();
    rst[3] = 1'b1;
    tick();
    chk("midrst.dataOut", got_do[3], 32'h0);
    chk("midrst.anyChange", 32'(got_any[3]), 32'h0);
    rst[3] = 1'b0;
    for (int j = 8; j <= 18; j++) begin
      tick();
      if (j == 16) chk("midrst.E16.dataOut", got_do[3], 32'h0);
      if (j == 17) begin
        chk("midrst.E17.dataOut", got_do[3], 32'h1);
        chk("midrst.E17.riseOut", got_ri[3], 32'h1);
      end
    end

    // Random levels held 2..20 cycles per channel, with rare reset pulses.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NI; k++) begin
        for (int b = 0; b < WA[k]; b++) begin
          if (hold[k][b] == 0) begin
            din[k][b]  = ~din[k][b];
            hold[k][b] = int'($urandom_range(1, 19));
          end else begin
            hold[k][b] = hold[k][b] - 1;
          end
        end
        if (rst[k]) rst[k] = 1'b0;
        else if ($urandom_range(0, 299) == 0) rst[k] = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
